// File: rtl/dmem_arbiter_if.sv
// -----------------------------------------------------------------------------
// dmem_arbiter_if
// One requester port of the data-memory arbiter.
//   req    level request, held until ack
//   we     1 = write, 0 = read
//   lock   ask to keep the grant on following cycles
//   addr   byte address (word accesses, [1:0] must be 00)
//   wdata  write data
//   ack    access accepted this cycle (combinational)
//   err    with ack: misaligned address, access suppressed
//   rvalid read data valid, one cycle after the read ack
//   rdata  read data, held until the next read on this port
// -----------------------------------------------------------------------------
interface dmem_arbiter_if;
  logic        req;
  logic        we;
  logic        lock;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ack;
  logic        err;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (
    output req, we, lock, addr, wdata,
    input  ack, err, rvalid, rdata
  );

  modport slave (
    input  req, we, lock, addr, wdata,
    output ack, err, rvalid, rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Shares one word-wide data memory between port 0 (CPU LSU) and port 1
// (DMA / debug loader). One access per cycle, ack in the request cycle,
// read data registered one cycle later. Round-robin or fixed priority,
// optional locked bursts bounded by LOCK_MAX grants.
//
// Ports:
//   i_clk        system clock
//   i_rst_n      asynchronous active-low reset
//   m0, m1       requester ports (dmem_arbiter_if.slave)
//   o_mem_addr   word-aligned address to the memory
//   o_mem_we     memory write enable
//   o_mem_wdata  memory write data
//   i_mem_rdata  memory read data (combinational read)
//   o_grant_id   port owning the memory this cycle (valid with an ack)
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | no burst in progress, normal arbitration
// S_LOCKED0| port 0 holds the memory while it keeps req and lock high
// S_LOCKED1| port 1 holds the memory while it keeps req and lock high
// -----------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int PRIORITY = 0,
  parameter int LOCK_MAX = 8,
  parameter int CNT_W    = 8
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  dmem_arbiter_if.slave m0,
  dmem_arbiter_if.slave m1,
  output logic [31:0]   o_mem_addr,
  output logic          o_mem_we,
  output logic [31:0]   o_mem_wdata,
  input  logic [31:0]   i_mem_rdata,
  output logic          o_grant_id
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LOCKED0 = 2'd1,
    S_LOCKED1 = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  // Remaining locked grants allowed after the current one; release at 1.
  logic [CNT_W-1:0]   r_lock_left;
  logic [CNT_W-1:0]   w_lock_left_nxt;
  logic               r_last_grant;
  // Set on a forced release: the other port must win the next conflict,
  // even under fixed priority.
  logic               r_force_other;
  logic               w_force_nxt;

  logic               w_any;
  logic               w_win;
  logic               w_lock;
  logic               w_we;
  logic               w_mis;
  logic               w_ack0;
  logic               w_ack1;
  logic [31:0]        w_addr;
  logic [31:0]        w_wdata;

  logic               r_rvalid0;
  logic               r_rvalid1;
  logic [31:0]        r_rdata0;
  logic [31:0]        r_rdata1;

  always_comb begin : arb
    w_any = 1'b0;
    w_win = 1'b0;
    if (r_state == S_LOCKED0 && m0.req) begin
      w_any = 1'b1;
      w_win = 1'b0;
    end else if (r_state == S_LOCKED1 && m1.req) begin
      w_any = 1'b1;
      w_win = 1'b1;
    end else if (m0.req && m1.req) begin
      w_any = 1'b1;
      w_win = (PRIORITY != 0 && !r_force_other) ? 1'b0 : ~r_last_grant;
    end else if (m0.req) begin
      w_any = 1'b1;
      w_win = 1'b0;
    end else if (m1.req) begin
      w_any = 1'b1;
      w_win = 1'b1;
    end
  end

  assign w_addr  = w_win ? m1.addr  : m0.addr;
  assign w_wdata = w_win ? m1.wdata : m0.wdata;
  assign w_we    = w_win ? m1.we    : m0.we;
  assign w_lock  = w_win ? m1.lock  : m0.lock;
  assign w_mis   = |w_addr[1:0];

  // Everything combinational is held quiet while reset is asserted.
  assign w_ack0 = i_rst_n & w_any & ~w_win;
  assign w_ack1 = i_rst_n & w_any &  w_win;

  always_comb begin : fsm
    w_state_nxt     = r_state;
    w_lock_left_nxt = r_lock_left;
    w_force_nxt     = r_force_other;
    if (w_any) w_force_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any && w_lock) begin
          if (LOCK_MAX <= 1) begin
            w_force_nxt = 1'b1;
          end else begin
            w_state_nxt     = w_win ? S_LOCKED1 : S_LOCKED0;
            w_lock_left_nxt = CNT_W'(LOCK_MAX - 1);
          end
        end
      end
      S_LOCKED0: begin
        // A grant that coincides with a release never re-locks.
        if (!(m0.req && m0.lock)) begin
          w_state_nxt = S_IDLE;
        end else if (r_lock_left == CNT_W'(1)) begin
          w_state_nxt = S_IDLE;
          w_force_nxt = 1'b1;
        end else begin
          w_lock_left_nxt = r_lock_left - CNT_W'(1);
        end
      end
      S_LOCKED1: begin
        if (!(m1.req && m1.lock)) begin
          w_state_nxt = S_IDLE;
        end else if (r_lock_left == CNT_W'(1)) begin
          w_state_nxt = S_IDLE;
          w_force_nxt = 1'b1;
        end else begin
          w_lock_left_nxt = r_lock_left - CNT_W'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= S_IDLE;
      r_lock_left   <= '0;
      r_last_grant  <= 1'b1;
      r_force_other <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_lock_left   <= w_lock_left_nxt;
      r_force_other <= w_force_nxt;
      if (w_any) r_last_grant <= w_win;
    end
  end

  // Misaligned reads still return a response, with zero data.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
      r_rdata0  <= '0;
      r_rdata1  <= '0;
    end else begin
      r_rvalid0 <= w_ack0 & ~m0.we;
      r_rvalid1 <= w_ack1 & ~m1.we;
      if (w_ack0 && !m0.we) r_rdata0 <= w_mis ? 32'd0 : i_mem_rdata;
      if (w_ack1 && !m1.we) r_rdata1 <= w_mis ? 32'd0 : i_mem_rdata;
    end
  end

  assign m0.ack    = w_ack0;
  assign m1.ack    = w_ack1;
  assign m0.err    = w_ack0 & w_mis;
  assign m1.err    = w_ack1 & w_mis;
  assign m0.rvalid = r_rvalid0;
  assign m1.rvalid = r_rvalid1;
  assign m0.rdata  = r_rdata0;
  assign m1.rdata  = r_rdata1;

  assign o_mem_addr  = (i_rst_n && w_any) ? {w_addr[31:2], 2'b00} : 32'd0;
  assign o_mem_wdata = (i_rst_n && w_any) ? w_wdata : 32'd0;
  assign o_mem_we    = i_rst_n & w_any & w_we & ~w_mis;
  assign o_grant_id  = i_rst_n & w_any & w_win;

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
// Two arbiters side by side (round-robin and fixed priority, LOCK_MAX=4),
// each with its own memory and stimulus, compared every cycle against a
// behavioural model of the arbitration rules. Directed scenarios first,
// then randomized traffic, then a full memory comparison.
// Flat index k = dut*2 + port; dut 0 = round-robin, dut 1 = fixed priority.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;
  localparam int LMAX = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic mem_clr;
  always #5 clk = ~clk;

  logic        t_req  [4];
  logic        t_we   [4];
  logic        t_lock [4];
  logic [31:0] t_addr [4];
  logic [31:0] t_wdata[4];
  logic        o_ack  [4];
  logic        o_err  [4];
  logic        o_rv   [4];
  logic [31:0] o_rd   [4];

  dmem_arbiter_if u_if[4] ();

  for (genvar k = 0; k < 4; k++) begin : g_if
    assign u_if[k].req   = t_req[k];
    assign u_if[k].we    = t_we[k];
    assign u_if[k].lock  = t_lock[k];
    assign u_if[k].addr  = t_addr[k];
    assign u_if[k].wdata = t_wdata[k];
    assign o_ack[k]      = u_if[k].ack;
    assign o_err[k]      = u_if[k].err;
    assign o_rv[k]       = u_if[k].rvalid;
    assign o_rd[k]       = u_if[k].rdata;
  end

  logic [31:0] mem_addr_rr, mem_wdata_rr, mem_rdata_rr, mem_addr_fp, mem_wdata_fp, mem_rdata_fp;
  logic        mem_we_rr, mem_we_fp, gid_rr, gid_fp;
  logic [31:0] mem_addr[2], mem_wdata[2];
  logic        mem_we[2], o_gid[2];
  logic [31:0] tb_mem[2][256];

  dmem_arbiter #(.PRIORITY(0), .LOCK_MAX(LMAX), .CNT_W(8)) u_dut_rr (
    .i_clk(clk), .i_rst_n(rst_n), .m0(u_if[0]), .m1(u_if[1]),
    .o_mem_addr(mem_addr_rr), .o_mem_we(mem_we_rr), .o_mem_wdata(mem_wdata_rr),
    .i_mem_rdata(mem_rdata_rr), .o_grant_id(gid_rr));

  dmem_arbiter #(.PRIORITY(1), .LOCK_MAX(LMAX), .CNT_W(8)) u_dut_fp (
    .i_clk(clk), .i_rst_n(rst_n), .m0(u_if[2]), .m1(u_if[3]),
    .o_mem_addr(mem_addr_fp), .o_mem_we(mem_we_fp), .o_mem_wdata(mem_wdata_fp),
    .i_mem_rdata(mem_rdata_fp), .o_grant_id(gid_fp));

  assign mem_addr[0]  = mem_addr_rr;
  assign mem_addr[1]  = mem_addr_fp;
  assign mem_wdata[0] = mem_wdata_rr;
  assign mem_wdata[1] = mem_wdata_fp;
  assign mem_we[0]    = mem_we_rr;
  assign mem_we[1]    = mem_we_fp;
  assign o_gid[0]     = gid_rr;
  assign o_gid[1]     = gid_fp;
  assign mem_rdata_rr = tb_mem[0][mem_addr_rr[9:2]];
  assign mem_rdata_fp = tb_mem[1][mem_addr_fp[9:2]];

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (mem_clr) begin
        for (int i = 0; i < 256; i++) tb_mem[d][i] <= 32'd0;
      end else if (mem_we[d]) begin
        tb_mem[d][mem_addr[d][9:2]] <= mem_wdata[d];
      end
    end
  end

  // ---------------- reference model ----------------
  int          m_owner[2];   // -1 none, else port holding a burst
  int          m_burst[2];   // grants so far in the burst
  bit          m_last[2];
  bit          m_force[2];
  bit          m_rv[4];
  logic [31:0] m_rd[4];
  logic [31:0] m_mem[2][256];
  bit          e_any[2];
  int          e_win[2];
  bit          e_ack[4];

  logic        s_ack[4], s_err[4], s_rv[4];
  logic [31:0] s_rd[4];
  logic        s_we[2], s_gid[2];

  int n_err = 0;
  int n_chk = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic string dn(input int d);
    return (d == 0) ? "rr" : "fp";
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_owner[d] = -1; m_burst[d] = 0; m_last[d] = 1'b1; m_force[d] = 1'b0;
    end
    for (int k = 0; k < 4; k++) begin m_rv[k] = 1'b0; m_rd[k] = 32'd0; end
  endtask

  task automatic predict(input int d);
    int k0, k1;
    k0 = d * 2; k1 = d * 2 + 1;
    e_any[d] = 1'b1;
    if (m_owner[d] == 0 && t_req[k0])       e_win[d] = 0;
    else if (m_owner[d] == 1 && t_req[k1])  e_win[d] = 1;
    else if (t_req[k0] && t_req[k1])        e_win[d] = (d == 1 && !m_force[d]) ? 0 : (m_last[d] ? 0 : 1);
    else if (t_req[k0])                     e_win[d] = 0;
    else if (t_req[k1])                     e_win[d] = 1;
    else begin e_any[d] = 1'b0; e_win[d] = 0; end
    e_ack[k0] = e_any[d] && e_win[d] == 0;
    e_ack[k1] = e_any[d] && e_win[d] == 1;
  endtask

  task automatic check_comb(input int d);
    int k;
    logic [31:0] a;
    bit mis;
    k = d * 2 + e_win[d];
    a = t_addr[k];
    mis = (a[1:0] != 2'b00);
    chk({dn(d), " ack0"}, o_ack[d*2],   e_ack[d*2]);
    chk({dn(d), " ack1"}, o_ack[d*2+1], e_ack[d*2+1]);
    chk({dn(d), " err0"}, o_err[d*2],   e_ack[d*2] && mis);
    chk({dn(d), " err1"}, o_err[d*2+1], e_ack[d*2+1] && mis);
    chk({dn(d), " mem_we"}, mem_we[d], e_any[d] && t_we[k] && !mis);
    chk({dn(d), " mem_addr"}, mem_addr[d], e_any[d] ? {a[31:2], 2'b00} : 32'd0);
    if (e_any[d]) begin
      chk({dn(d), " mem_wdata"}, mem_wdata[d], t_wdata[k]);
      chk({dn(d), " grant_id"}, o_gid[d], e_win[d]);
    end
    for (int p = 0; p < 2; p++) begin s_ack[d*2+p] = o_ack[d*2+p]; s_err[d*2+p] = o_err[d*2+p]; end
    s_we[d]  = mem_we[d];
    s_gid[d] = o_gid[d];
  endtask

  task automatic model_edge(input int d);
    int k, x, kx;
    logic [31:0] a;
    bit mis;
    m_rv[d*2] = 1'b0; m_rv[d*2+1] = 1'b0;
    k = d * 2 + e_win[d];
    a = t_addr[k];
    mis = (a[1:0] != 2'b00);
    if (e_any[d]) begin
      if (!t_we[k]) begin
        m_rv[k] = 1'b1;
        m_rd[k] = mis ? 32'd0 : m_mem[d][a[9:2]];
      end else if (!mis) begin
        m_mem[d][a[9:2]] = t_wdata[k];
      end
      m_last[d]  = e_win[d][0];
      m_force[d] = 1'b0;
    end
    if (m_owner[d] < 0) begin
      if (e_any[d] && t_lock[k]) begin
        if (LMAX == 1) m_force[d] = 1'b1;
        else begin m_owner[d] = e_win[d]; m_burst[d] = 1; end
      end
    end else begin
      x = m_owner[d]; kx = d * 2 + x;
      if (t_req[kx] && t_lock[kx]) begin
        m_burst[d]++;
        if (m_burst[d] == LMAX) begin m_owner[d] = -1; m_force[d] = 1'b1; end
      end else begin
        m_owner[d] = -1;
      end
    end
  endtask

  task automatic check_reg(input int d);
    for (int p = 0; p < 2; p++) begin
      chk({dn(d), $sformatf(" rvalid%0d", p)}, o_rv[d*2+p], m_rv[d*2+p]);
      chk({dn(d), $sformatf(" rdata%0d", p)},  o_rd[d*2+p], m_rd[d*2+p]);
      s_rv[d*2+p] = o_rv[d*2+p];
      s_rd[d*2+p] = o_rd[d*2+p];
    end
  endtask

  // Entered and left at posedge+1.
  task automatic cycle();
    #3;
    for (int d = 0; d < 2; d++) begin predict(d); check_comb(d); end
    @(posedge clk);
    for (int d = 0; d < 2; d++) model_edge(d);
    #1;
    for (int d = 0; d < 2; d++) check_reg(d);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < 2; p++) begin
        chk({dn(d), " rst ack"},    o_ack[d*2+p], 1'b0);
        chk({dn(d), " rst rvalid"}, o_rv[d*2+p],  1'b0);
        chk({dn(d), " rst rdata"},  o_rd[d*2+p],  32'd0);
      end
      chk({dn(d), " rst mem_we"},   mem_we[d],   1'b0);
      chk({dn(d), " rst mem_addr"}, mem_addr[d], 32'd0);
    end
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Same directed stimulus on port p of both arbiters.
  task automatic drv(input int p, input bit req, input bit we, input bit lock,
                     input logic [31:0] addr, input logic [31:0] wd);
    for (int d = 0; d < 2; d++) begin
      t_req[d*2+p] = req; t_we[d*2+p] = we; t_lock[d*2+p] = lock;
      t_addr[d*2+p] = addr; t_wdata[d*2+p] = wd;
    end
  endtask

  initial begin
    int cnt0, cnt1, w, off;
    rst_n = 1'b1;
    mem_clr = 1'b1;
    for (int k = 0; k < 4; k++) begin
      t_req[k] = 0; t_we[k] = 0; t_lock[k] = 0; t_addr[k] = 0; t_wdata[k] = 0;
    end
    for (int d = 0; d < 2; d++) for (int i = 0; i < 256; i++) m_mem[d][i] = 32'd0;
    model_reset();
    #1;
    do_reset();
    mem_clr = 1'b0;

    // single write then read on the other port
    drv(0, 1, 1, 0, 32'h40, 32'hDEADBEEF); drv(1, 0, 0, 0, 0, 0);
    cycle();
    drv(0, 0, 0, 0, 0, 0); drv(1, 1, 0, 0, 32'h40, 0);
    cycle();
    for (int d = 0; d < 2; d++) begin
      chk({dn(d), " t1 ack1"},   s_ack[d*2+1], 1'b1);
      chk({dn(d), " t1 rvalid"}, s_rv[d*2+1],  1'b1);
      chk({dn(d), " t1 rdata"},  s_rd[d*2+1],  32'hDEADBEEF);
    end
    drv(1, 0, 0, 0, 0, 0);
    cycle();

    // conflict: rr alternates 0,1,0,1; fp always port 0
    do_reset();
    drv(0, 1, 0, 0, 32'h10, 0); drv(1, 1, 0, 0, 32'h20, 0);
    cnt0 = 0; cnt1 = 0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("rr conflict gid", s_gid[0], i % 2);
      chk("fp conflict gid", s_gid[1], 0);
      cnt0 += s_ack[0]; cnt1 += s_ack[1];
    end
    chk("rr conflict acks0", cnt0, 2);
    chk("rr conflict acks1", cnt1, 2);
    drv(0, 0, 0, 0, 0, 0);
    cycle();
    chk("fp late ack1", s_ack[3], 1'b1);
    drv(1, 0, 0, 0, 0, 0);
    cycle();

    // lock starvation guard: 4 locked grants to port 0, then port 1
    do_reset();
    drv(0, 1, 0, 1, 32'h10, 0); drv(1, 1, 0, 0, 32'h20, 0);
    for (int i = 0; i < 5; i++) begin
      cycle();
      for (int d = 0; d < 2; d++) chk({dn(d), " guard gid"}, s_gid[d], (i == 4) ? 1 : 0);
    end
    drv(0, 0, 0, 0, 0, 0); drv(1, 0, 0, 0, 0, 0);
    cycle();

    // misaligned write leaves the word untouched; misaligned read returns 0
    drv(0, 1, 1, 0, 32'h20, 32'h12345678);
    cycle();
    drv(0, 0, 0, 0, 0, 0); drv(1, 1, 1, 0, 32'h22, 32'h55);
    cycle();
    for (int d = 0; d < 2; d++) begin
      chk({dn(d), " mis ack1"},   s_ack[d*2+1], 1'b1);
      chk({dn(d), " mis err1"},   s_err[d*2+1], 1'b1);
      chk({dn(d), " mis mem_we"}, s_we[d],      1'b0);
    end
    drv(1, 0, 0, 0, 0, 0); drv(0, 1, 0, 0, 32'h20, 0);
    cycle();
    for (int d = 0; d < 2; d++) chk({dn(d), " mis word kept"}, s_rd[d*2], 32'h12345678);
    drv(0, 0, 0, 0, 0, 0); drv(1, 1, 0, 0, 32'h23, 0);
    cycle();
    for (int d = 0; d < 2; d++) begin
      chk({dn(d), " mis rd rvalid"}, s_rv[d*2+1], 1'b1);
      chk({dn(d), " mis rd rdata"},  s_rd[d*2+1], 32'd0);
    end

    // reset in the middle of a port 1 locked read burst
    drv(1, 1, 0, 1, 32'h40, 0);
    cycle();
    cycle();
    for (int d = 0; d < 2; d++) chk({dn(d), " lock rvalid"}, s_rv[d*2+1], 1'b1);
    do_reset();
    drv(0, 1, 0, 0, 32'h10, 0); drv(1, 1, 0, 0, 32'h20, 0);
    cycle();
    for (int d = 0; d < 2; d++) chk({dn(d), " post-rst gid"}, s_gid[d], 0);
    drv(0, 0, 0, 0, 0, 0); drv(1, 0, 0, 0, 0, 0);
    cycle();

    // randomized traffic; a pending request is held until acked
    for (int n = 0; n < 1500; n++) begin
      for (int k = 0; k < 4; k++) begin
        if (!(t_req[k] && !e_ack[k])) begin
          if ($urandom_range(0, 3) != 0) begin
            w   = $urandom_range(0, 15);
            off = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0;
            t_req[k]   = 1'b1;
            t_we[k]    = $urandom_range(0, 1) == 1;
            t_lock[k]  = $urandom_range(0, 2) != 0;
            t_addr[k]  = 32'(w * 4 + off) | (($urandom_range(0, 3) == 0) ? 32'h8000_0000 : 32'd0);
            t_wdata[k] = $urandom;
          end else begin
            t_req[k]  = 1'b0;
            t_lock[k] = $urandom_range(0, 1) == 1;
          end
        end
      end
      if ($urandom_range(0, 299) == 0) do_reset();
      else cycle();
    end

    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 256; i++)
        chk($sformatf("%s mem[%0d]", dn(d), i), tb_mem[d][i], m_mem[d][i]);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-port arbiter that shares the single word-wide data memory between port 0 (CPU load/store unit) and port 1 (DMA/debug loader).
- Sits directly in front of the DataMem instance: one access per cycle, round-robin or fixed priority, optional locked bursts with a starvation guard, and misalignment error reporting.
- Read data is registered and returned one cycle after grant.

Parameters:
- PRIORITY, 0, arbitration mode: 0 = round-robin, 1 = fixed priority to port 0.
- LOCK_MAX, 8, maximum consecutive locked grants to one port before forced release (1..255).
- CNT_W, 8, width of the lock counter. Must satisfy 2^CNT_W > LOCK_MAX.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- m0_req  in  1  port 0 access request, level, held until m0_ack
- m0_we  in  1  port 0 write (1) / read (0)
- m0_lock  in  1  port 0 requests to keep grant on following cycles
- m0_addr  in  32  port 0 byte address
- m0_wdata  in  32  port 0 write data
- m0_ack  out  1  port 0 access accepted this cycle (combinational)
- m0_err  out  1  with m0_ack: address misaligned, access suppressed
- m0_rvalid  out  1  port 0 read data valid (registered, 1 cycle after ack of a read)
- m0_rdata  out  32  port 0 read data
- m1_req, m1_we, m1_lock, m1_addr, m1_wdata, m1_ack, m1_err, m1_rvalid, m1_rdata: same as port 0, for port 1
- mem_addr  out  32  to DataMem addr
- mem_we  out  1  to DataMem we
- mem_wdata  out  32  to DataMem wdata
- mem_rdata  in  32  from DataMem rdata (combinational read)
- grant_id  out  1  port owning memory this cycle (valid when any ack)

Behaviour:
- Reset (rst_n=0, async):
  - state=IDLE, lock_cnt=0, last_grant=1 (so port 0 wins the first conflict).
  - m0/m1_rvalid=0, m0/m1_rdata=0.
  - Combinational outputs are forced quiet: acks=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - Reset mid-burst drops the lock; an in-flight rvalid is cancelled.
- Grant selection (combinational, each cycle):
  - Only one port requesting: that port wins.
  - Both requesting, PRIORITY=1: port 0 wins.
  - Both requesting, PRIORITY=0: the port != last_grant wins.
  - state LOCKEDx with mx_req=1 overrides both rules: port x wins.
- Winner datapath:
  - mx_ack=1 for the winner; the loser's ack=0.
  - mem_addr=winner addr with [1:0] forced to 00, mem_wdata=winner wdata, grant_id=winner.
  - No requester: acks=0, mem_we=0, mem_addr=0.
- Misaligned access (winner addr[1:0]!=0): mx_ack=1, mx_err=1, mem_we=0. A misaligned read produces rvalid=1 with rdata=0 next cycle. Error accesses still update last_grant.
- Write: mem_we=1 in the ack cycle; the memory commits on that rising edge; no rvalid.
- Read: on the ack edge, mx_rdata<=mem_rdata and mx_rvalid<=1. rvalid is a one-cycle pulse. rdata holds its value until the next read to that port.
- Back-to-back reads to the same port give rvalid high on consecutive cycles.
- last_grant<=winner on every ack edge.
- FSM (IDLE, LOCKED0, LOCKED1):
  - IDLE -> LOCKEDx when port x is acked with mx_lock=1; lock_cnt<=1.
  - LOCKEDx, mx_req=1, mx_lock=1, lock_cnt<LOCK_MAX: stay, lock_cnt+1.
  - LOCKEDx -> IDLE when mx_req=0, mx_lock=0, or lock_cnt==LOCK_MAX. On the forced release edge, last_grant=x, so the other port wins the next conflict regardless of PRIORITY.
  - If x requests in LOCKEDx with lock=0, that access is still granted, then the state returns to IDLE.
  - The LOCKEDx -> LOCKEDy transition is not allowed directly; it must pass through IDLE. An ack in the same cycle as a release cannot re-lock.
- Latency: ack same cycle as req (0 wait states when winning); read data +1 cycle.
- Throughput: one access per cycle.

Test Plan:
- Single read: write 0xDEADBEEF to 0x40 via port 0, then read 0x40 via port 1 → m1_ack same cycle, next cycle m1_rvalid=1 and m1_rdata=0xDEADBEEF.
- Conflict, PRIORITY=0: both ports hold req for 4 cycles with addrs 0x10 and 0x20 → grant_id sequence 0,1,0,1; each port gets 2 acks.
- Conflict, PRIORITY=1: both request for 3 cycles → port 0 acked all 3 cycles; port 1 acked only after m0_req drops.
- Lock starvation guard: LOCK_MAX=4, port 0 requests with lock held and port 1 requests continuously → port 0 gets 4 acks, port 1 is acked on cycle 5, state returns to IDLE.
- Misaligned: port 1 writes 0x55 to 0x22 → m1_ack=1, m1_err=1, mem_we=0, memory word 0x20 unchanged. A read of 0x23 → rvalid=1, rdata=0.
- Reset mid-lock: port 1 in LOCKED1, rst_n low for 1 cycle during a read ack → rvalid=0 immediately. After release, both request → port 0 wins first.
